// File: rtl/mux_n_1_arb.sv
// N-input, W-bit arbitrating multiplexer with a single registered output stage.
// Grant modes: explicit select, fixed priority (lowest index first) and round-robin.
module mux_n_1_arb #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [N*W-1:0]    d_in,
    input  logic [N-1:0]      valid_in,
    output logic [N-1:0]      ready_out,
    input  logic [1:0]        mode_in,
    input  logic [SELW-1:0]   sel_in,
    output logic [W-1:0]      y_out,
    output logic              y_valid_out,
    input  logic              y_ready_in,
    output logic [SELW-1:0]   y_sel_out
);

    logic              load_s;
    logic              grant_valid_s;
    logic [SELW-1:0]   grant_idx_s;
    logic [W-1:0]      grant_data_s;
    logic              xfer_s;

    logic [W-1:0]      y_d, y_q;
    logic              y_valid_d, y_valid_q;
    logic [SELW-1:0]   y_sel_d, y_sel_q;
    logic [SELW-1:0]   rr_ptr_d, rr_ptr_q;

    assign load_s = ~y_valid_q | y_ready_in;

    // Grant selection for the current cycle
    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        case (mode_in)
            2'd0: begin
                // Out-of-range indices never match any channel, so they never grant.
                for (int i = 0; i < N; i++) begin
                    if ((sel_in == SELW'(i)) && valid_in[i]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SELW'(i);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
            2'd2: begin
                // Walk the search order backwards so the last hit is the first in order.
                for (int k = N - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr_q) + k;
                    idx = (idx >= N) ? (idx - N) : idx;
                    if (valid_in[idx]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SELW'(idx);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (valid_in[i]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SELW'(i);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
        endcase
    end

    // One-hot ready and granted data selection
    always_comb begin
        ready_out    = '0;
        grant_data_s = '0;
        for (int i = 0; i < N; i++) begin
            ready_out[i] = rst_n_in & load_s & grant_valid_s & (grant_idx_s == SELW'(i));
            grant_data_s = grant_data_s | (d_in[i*W +: W] & {W{grant_idx_s == SELW'(i)}});
        end
    end

    assign xfer_s = |(valid_in & ready_out);

    // Next-state for the output register and round-robin pointer
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_sel_d   = y_sel_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer_s) begin
            y_d       = grant_data_s;
            y_sel_d   = grant_idx_s;
            y_valid_d = 1'b1;
            if (mode_in == 2'd2) begin
                rr_ptr_d = (grant_idx_s == SELW'(N - 1)) ? '0 : (grant_idx_s + SELW'(1));
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (load_s) begin
            y_valid_d = 1'b0;
        end else begin
            y_valid_d = y_valid_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_sel_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_sel_q   <= y_sel_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign y_out       = y_q;
    assign y_valid_out = y_valid_q;
    assign y_sel_out   = y_sel_q;

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Directed self-checking bench for mux_n_1_arb with N=4, W=8.
module tb_mux_n_1_arb;

    logic        clk_in;
    logic        rst_n_in;
    logic [31:0] d_in;
    logic [3:0]  valid_in;
    logic [3:0]  ready_out;
    logic [1:0]  mode_in;
    logic [1:0]  sel_in;
    logic [7:0]  y_out;
    logic        y_valid_out;
    logic        y_ready_in;
    logic [1:0]  y_sel_out;

    int n_cmp;
    int n_err;

    mux_n_1_arb #(.N(4), .W(8), .SELW(2)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .d_in        (d_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .mode_in     (mode_in),
        .sel_in      (sel_in),
        .y_out       (y_out),
        .y_valid_out (y_valid_out),
        .y_ready_in  (y_ready_in),
        .y_sel_out   (y_sel_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [7:0] dat, input logic [1:0] sel);
        check_val({tag, "_vld"}, {31'd0, y_valid_out}, {31'd0, vld});
        check_val({tag, "_dat"}, {24'd0, y_out}, {24'd0, dat});
        check_val({tag, "_sel"}, {30'd0, y_sel_out}, {30'd0, sel});
    endtask

    task automatic check_rdy(input string tag, input logic [3:0] exp);
        #1;
        check_val(tag, {28'd0, ready_out}, {28'd0, exp});
    endtask

    logic [1:0] rr_sel_exp [6];
    logic [7:0] rr_dat_exp [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rr_sel_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_dat_exp = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0, 8'hB1};

        // Reset with all channels valid
        rst_n_in   = 1'b0;
        valid_in   = 4'b1111;
        mode_in    = 2'd0;
        sel_in     = 2'd0;
        y_ready_in = 1'b1;
        d_in       = 32'hD3C2B1A0;
        check_rdy("rst_rdy0", 4'b0000);
        tick();
        check_out("rst1", 1'b0, 8'h00, 2'd0);
        check_rdy("rst_rdy1", 4'b0000);
        tick();
        check_out("rst2", 1'b0, 8'h00, 2'd0);
        rst_n_in = 1'b1;
        valid_in = 4'b0000;
        check_rdy("idle_rdy", 4'b0000);
        tick();
        check_out("idle", 1'b0, 8'h00, 2'd0);

        // Mode 0: explicit select 0,3,1,2
        mode_in  = 2'd0;
        valid_in = 4'b1111;
        sel_in = 2'd0; check_rdy("m0_rdy0", 4'b0001); tick(); check_out("m0_s0", 1'b1, 8'hA0, 2'd0);
        sel_in = 2'd3; check_rdy("m0_rdy3", 4'b1000); tick(); check_out("m0_s3", 1'b1, 8'hD3, 2'd3);
        sel_in = 2'd1; check_rdy("m0_rdy1", 4'b0010); tick(); check_out("m0_s1", 1'b1, 8'hB1, 2'd1);
        sel_in = 2'd2; check_rdy("m0_rdy2", 4'b0100); tick(); check_out("m0_s2", 1'b1, 8'hC2, 2'd2);
        valid_in = 4'b1011;
        check_rdy("m0_nogrant_rdy", 4'b0000);
        tick();
        check_out("m0_nogrant", 1'b0, 8'hC2, 2'd2);

        // Mode 1: fixed priority
        mode_in  = 2'd1;
        valid_in = 4'b1010; check_rdy("m1_rdy_a", 4'b0010); tick(); check_out("m1_a", 1'b1, 8'hB1, 2'd1);
        valid_in = 4'b1000; check_rdy("m1_rdy_b", 4'b1000); tick(); check_out("m1_b", 1'b1, 8'hD3, 2'd3);
        mode_in  = 2'd3;
        valid_in = 4'b0110; check_rdy("m3_rdy", 4'b0010); tick(); check_out("m3", 1'b1, 8'hB1, 2'd1);

        // Mode 2: round-robin with wrap, pointer starts at 0
        mode_in  = 2'd2;
        valid_in = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out($sformatf("rr_%0d", i), 1'b1, rr_dat_exp[i], rr_sel_exp[i]);
        end
        // Pointer now 2: sparse valids grant 2, 0, 2
        valid_in = 4'b0101;
        check_rdy("rr_sp_rdy0", 4'b0100); tick(); check_out("rr_sp0", 1'b1, 8'hC2, 2'd2);
        check_rdy("rr_sp_rdy1", 4'b0001); tick(); check_out("rr_sp1", 1'b1, 8'hA0, 2'd0);
        check_rdy("rr_sp_rdy2", 4'b0100); tick(); check_out("rr_sp2", 1'b1, 8'hC2, 2'd2);

        // Backpressure: load A0 then stall three cycles while data changes
        mode_in  = 2'd0;
        sel_in   = 2'd0;
        valid_in = 4'b1111;
        tick();
        check_out("bp_load", 1'b1, 8'hA0, 2'd0);
        y_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_in = 32'h44332211 + 32'(i);
            check_rdy($sformatf("bp_rdy%0d", i), 4'b0000);
            tick();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 8'hA0, 2'd0);
        end
        d_in       = 32'h44332211;
        sel_in     = 2'd1;
        y_ready_in = 1'b1;
        check_rdy("bp_release_rdy", 4'b0010);
        tick();
        check_out("bp_release", 1'b1, 8'h22, 2'd1);

        // Reset mid-operation with stalled output and pointer at 3
        y_ready_in = 1'b0;
        rst_n_in   = 1'b0;
        check_rdy("mid_rst_rdy", 4'b0000);
        tick();
        check_out("mid_rst", 1'b0, 8'h00, 2'd0);
        rst_n_in   = 1'b1;
        mode_in    = 2'd2;
        valid_in   = 4'b1111;
        y_ready_in = 1'b1;
        d_in       = 32'hD3C2B1A0;
        check_rdy("post_rst_rdy", 4'b0001);
        tick();
        check_out("post_rst0", 1'b1, 8'hA0, 2'd0);
        tick();
        check_out("post_rst1", 1'b1, 8'hB1, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_1_arb.md
# mux_n_1_arb

Parametrised N-input, W-bit registered multiplexer that arbitrates between valid/ready input channels and drives a single registered output channel. It generalises the 4:1 select mux to any channel count and data width. It adds three run-time selection modes (explicit select, fixed priority, round-robin) and a one-stage output register with backpressure. It sits between multiple producers and one shared downstream consumer.

## Interface
- N, default 4: number of input channels, N ≥ 2.
- W, default 8: data width per channel.
- SELW, default 2: select/index width, set to ceil(log2(N)), minimum 1.
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- d_in  input  N*W  channel data; channel i occupies d_in[i*W +: W].
- valid_in  input  N  per-channel valid.
- ready_out  output  N  per-channel ready; combinational.
- mode_in  input  2  0 = explicit select, 1 = fixed priority, 2 = round-robin, 3 = reserved (behaves as 1).
- sel_in  input  SELW  channel index used in mode 0.
- y_out  output  W  registered output data.
- y_valid_out  output  1  registered output valid.
- y_ready_in  input  1  downstream ready.
- y_sel_out  output  SELW  registered index of the channel that produced y_out.

## Operation
- load = ~y_valid_out | y_ready_in. The output register may accept a new word only when load is 1.
- Grant g is combinational and is computed every cycle from valid_in, mode_in, sel_in and rr_ptr:
  - Mode 0: g = sel_in if sel_in < N and valid_in[sel_in] = 1; otherwise no grant. Indices ≥ N never grant.
  - Mode 1/3: g = lowest index i with valid_in[i] = 1.
  - Mode 2: g = first i with valid_in[i] = 1, searching rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 (modulo N).
- ready_out[i] = load & grant_valid & (g == i). At most one bit is set. All bits are 0 during reset.
- Transfer on input i: valid_in[i] & ready_out[i] at a clock edge. On a transfer:
  - y_out ← d_in[g*W +: W].
  - y_sel_out ← g.
  - y_valid_out ← 1.
- load = 1 with no grant: y_valid_out ← 0; y_out and y_sel_out hold.
- Output handshake: y_valid_out & y_ready_in completes the output transfer. y_out is stable while y_valid_out = 1 and y_ready_in = 0.
- rr_ptr (SELW bits):
  - After any transfer in mode 2, rr_ptr ← (g+1) mod N, wrapping from N-1 to 0.
  - rr_ptr holds in modes 0, 1 and 3, and when there is no transfer.
- mode_in and sel_in are sampled every cycle with no internal latching. A mode change applies to the grant in the same cycle. rr_ptr is not cleared on a mode change.
- Reset (rst_n_in = 0 at an edge) sets y_out = 0, y_valid_out = 0, y_sel_out = 0, rr_ptr = 0.
- Reset mid-transfer drops any word held in the output register. No input transfer occurs in a reset cycle.

## Timing
- Latency: 1 cycle from input transfer to y_valid_out = 1 carrying that word.
- Throughput: one word per cycle while y_ready_in = 1.
- Combinational paths: y_ready_in → ready_out, and valid_in/mode_in/sel_in → ready_out. No combinational path to y_out, y_valid_out or y_sel_out.
- First cycle after reset release: ready_out may assert if any valid_in is set, because y_valid_out = 0 makes load = 1.
- Backpressure: if y_valid_out = 1 and y_ready_in = 0, ready_out = 0 and all registers hold.

## Test plan
- Reset and idle: hold rst_n_in = 0 for 2 cycles with valid_in = 4'b1111, then release with valid_in = 0. Required: y_valid_out = 0, y_out = 0, y_sel_out = 0, ready_out = 0 throughout.
- Mode 0: d_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, valid_in = 4'b1111, y_ready_in = 1, sel_in stepped 0 → 3 → 1 → 2. Required: after 1-cycle latency, y_out = A0, D3, B1, C2 with y_sel_out = 0, 3, 1, 2. Separately, sel_in = 2 with valid_in[2] = 0 → ready_out = 0 and y_valid_out falls.
- Mode 1: valid_in = 4'b1010 → grant 1. Next cycle valid_in = 4'b1000 → grant 3. Required: ready_out = 4'b0010 then 4'b1000.
- Mode 2: valid_in = 4'b1111 held for 6 cycles, y_ready_in = 1. Required: y_sel_out sequence 0, 1, 2, 3, 0, 1 (wrap-around). Then valid_in = 4'b0101 with rr_ptr = 2 → grants 2, 0, 2.
- Backpressure: y_valid_out = 1 with y_out = 8'hA0, y_ready_in = 0 for 3 cycles while d_in changes. Required: ready_out = 0, y_out held at A0. When y_ready_in rises, the next word loads in the same cycle.
- Reset mid-operation: assert rst_n_in while y_valid_out = 1, y_ready_in = 0 and rr_ptr = 3. Required: next cycle y_valid_out = 0, y_out = 0. After release in mode 2 with valid_in = 4'b1111, first grant = 0.
